// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared multiplier constants
package mul_pkg;

    localparam int MUL_WIDTH = 64;

    localparam logic MUL_OP_LO = 1'b0;
    localparam logic MUL_OP_HI = 1'b1;

endpackage

// File: rtl/mul_res_fifo.sv
// rtl/mul_res_fifo.sv - generic in-order result FIFO with full/empty flags
module mul_res_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_fire, rd_fire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_fire = rd_ready && !empty;
    // A full FIFO may still accept a write in the cycle its head is consumed.
    assign wr_fire = wr_valid && (!full || rd_fire);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            if (wr_fire) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (rd_fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

endmodule

// File: rtl/mul_final_adder.sv
// rtl/mul_final_adder.sv - multiplier final carry-propagate add with credit-guarded result FIFO
module mul_final_adder
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               issue_fire,
    output logic               can_issue,
    input  logic               tree_valid,
    input  logic [WIDTH-1:0]   tree_c,
    input  logic [WIDTH-1:0]   tree_s,
    input  logic               tree_cin,
    input  logic               tree_op,
    input  logic [TAGW-1:0]    tree_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] out_data,
    output logic [TAGW-1:0]    out_tag
);

    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_fire;

    logic [WIDTH-1:0] c_shift;
    logic [H:0]       lo_sum;
    logic             unused_c_msb;

    logic             a_valid_q, a_carry_q, a_op_q;
    logic [H-1:0]     a_lo_q, a_s_hi_q, a_c_hi_q;
    logic [TAGW-1:0]  a_tag_q;

    logic [H-1:0]     b_hi;
    logic             b_valid_q;
    logic [H-1:0]     b_data_q;
    logic [TAGW-1:0]  b_tag_q;

    logic             fifo_full, fifo_empty;

    assign out_fire  = out_valid && out_ready;
    assign can_issue = (cnt_q < CW'(DEPTH));

    always_comb begin
        cnt_d = cnt_q;
        case ({issue_fire, out_fire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Column carries shift up one place; the top column carry falls off the product.
    assign c_shift      = {tree_c[WIDTH-2:0], tree_cin};
    assign unused_c_msb = tree_c[WIDTH-1];
    assign lo_sum       = {1'b0, tree_s[H-1:0]} + {1'b0, c_shift[H-1:0]};
    assign b_hi         = a_s_hi_q + a_c_hi_q + H'(a_carry_q);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            a_valid_q <= 1'b0;
            a_carry_q <= 1'b0;
            a_op_q    <= MUL_OP_LO;
            a_lo_q    <= '0;
            a_s_hi_q  <= '0;
            a_c_hi_q  <= '0;
            a_tag_q   <= '0;
            b_valid_q <= 1'b0;
            b_data_q  <= '0;
            b_tag_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            a_valid_q <= tree_valid;
            if (tree_valid) begin
                a_lo_q    <= lo_sum[H-1:0];
                a_carry_q <= lo_sum[H];
                a_s_hi_q  <= tree_s[WIDTH-1:H];
                a_c_hi_q  <= c_shift[WIDTH-1:H];
                a_op_q    <= tree_op;
                a_tag_q   <= tree_tag;
            end
            b_valid_q <= a_valid_q;
            if (a_valid_q) begin
                b_data_q <= (a_op_q == MUL_OP_HI) ? b_hi : a_lo_q;
                b_tag_q  <= a_tag_q;
            end
        end
    end

    mul_res_fifo #(
        .WIDTH (H + TAGW),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clock    (clock),
        .resetn   (resetn),
        .wr_valid (b_valid_q),
        .wr_data  ({b_tag_q, b_data_q}),
        .rd_ready (out_ready),
        .rd_data  ({out_tag, out_data}),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign out_valid = !fifo_empty;

    a_issue_credit: assert property (@(posedge clock) disable iff (!resetn)
        issue_fire |-> can_issue);
    a_tree_outstanding: assert property (@(posedge clock) disable iff (!resetn)
        tree_valid |-> (cnt_q != '0));
    a_fifo_overflow: assert property (@(posedge clock) disable iff (!resetn)
        (b_valid_q && fifo_full) |-> out_ready);

endmodule

// File: tb/tb_mul_final_adder.sv
// tb/tb_mul_final_adder.sv - self-checking bench for mul_final_adder
module tb_mul_final_adder;
    import mul_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic        issue_fire, can_issue;
    logic        tree_valid, tree_cin, tree_op;
    logic [63:0] tree_c, tree_s;
    logic [3:0]  tree_tag, out_tag;
    logic        out_valid, out_ready;
    logic [31:0] out_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        v;
        logic [63:0] s;
        logic [63:0] c;
        logic        cin;
        logic        op;
        logic [3:0]  tag;
    } op_t;

    always #5 clock = ~clock;

    mul_final_adder #(.WIDTH(64), .DEPTH(DEPTH), .TAGW(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .issue_fire (issue_fire),
        .can_issue  (can_issue),
        .tree_valid (tree_valid),
        .tree_c     (tree_c),
        .tree_s     (tree_s),
        .tree_cin   (tree_cin),
        .tree_op    (tree_op),
        .tree_tag   (tree_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] ref_half(input logic [63:0] s, input logic [63:0] c,
                                             input logic cin, input logic op);
        logic [63:0] p;
        p = s + ((c << 1) | {63'd0, cin});
        return op ? p[63:32] : p[31:0];
    endfunction

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        v = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) v = '1;
        return v;
    endfunction

    task automatic drive_tree(input logic [63:0] s, input logic [63:0] c, input logic cin,
                              input logic op, input logic [3:0] tag);
        tree_valid = 1'b1;
        tree_s     = s;
        tree_c     = c;
        tree_cin   = cin;
        tree_op    = op;
        tree_tag   = tag;
    endtask

    task automatic send(input logic [63:0] s, input logic [63:0] c, input logic cin,
                        input logic op, input logic [3:0] tag);
        issue_fire = 1'b1;
        tick();
        issue_fire = 1'b0;
        drive_tree(s, c, cin, op, tag);
        tick();
        tree_valid = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [63:0] s, input logic [63:0] c,
                         input logic cin, input logic op, input logic [3:0] tag,
                         input logic [31:0] exp);
        issue_fire = 1'b1;
        tick();
        issue_fire = 1'b0;
        drive_tree(s, c, cin, op, tag);
        tick();
        tree_valid = 1'b0;
        tick();
        check({name, "_not_early"}, out_valid, 1'b0);
        tick();
        check({name, "_valid_t3"}, out_valid, 1'b1);
        check({name, "_data"}, out_data, exp);
        check({name, "_tag"}, out_tag, tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_popped"}, out_valid, 1'b0);
    endtask

    logic [31:0] exp_d [8];
    logic [63:0] rs, rc;
    logic        rcin;

    initial begin
        op_t         p0, p1, nop;
        logic [35:0] expq[$];
        logic [35:0] e;
        logic [3:0]  next_tag;
        int          cnt_m;
        bit          issue, fire;

        resetn = 1'b0; issue_fire = 1'b0; tree_valid = 1'b0; out_ready = 1'b0;
        tree_s = '0; tree_c = '0; tree_cin = 1'b0; tree_op = MUL_OP_LO; tree_tag = '0;
        tick(); tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_tag", out_tag, 4'h0);
        check("rst_can_issue", can_issue, 1'b1);
        resetn = 1'b1;
        tick();

        do_op("t1_single", 64'h1, 64'h0, 1'b1, MUL_OP_LO, 4'd3, 32'h2);
        do_op("t2_carry_hi", 64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, MUL_OP_HI, 4'd5, 32'h1);
        do_op("t2_carry_lo", 64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, MUL_OP_LO, 4'd6, 32'h0);
        do_op("t3_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1,
              MUL_OP_HI, 4'd7, 32'h0);

        // Backpressure: fill all credits, then drain in order.
        for (int i = 0; i < 4; i++) begin
            rs = rnd64(); rc = rnd64(); rcin = 1'($urandom_range(0, 1));
            exp_d[i] = ref_half(rs, rc, rcin, 1'(i & 1));
            send(rs, rc, rcin, 1'(i & 1), 4'(i));
        end
        check("t4_no_credit", can_issue, 1'b0);
        tick(); tick(); tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4_valid", out_valid, 1'b1);
            check("t4_tag", out_tag, 4'(i));
            check("t4_data", out_data, exp_d[i]);
            tick();
            if (i == 0) check("t4_credit_back", can_issue, 1'b1);
        end
        out_ready = 1'b0;
        check("t4_empty", out_valid, 1'b0);

        // Simultaneous issue and consume at DEPTH-1 outstanding.
        for (int i = 0; i < 3; i++) begin
            rs = rnd64(); rc = rnd64(); rcin = 1'($urandom_range(0, 1));
            exp_d[i] = ref_half(rs, rc, rcin, MUL_OP_LO);
            send(rs, rc, rcin, MUL_OP_LO, 4'(i));
        end
        tick(); tick(); tick();
        check("t5_three_out", can_issue, 1'b1);
        issue_fire = 1'b1; out_ready = 1'b1;
        tick();
        issue_fire = 1'b0; out_ready = 1'b0;
        check("t5_simul_credit", can_issue, 1'b1);
        rs = rnd64(); rc = rnd64(); exp_d[3] = ref_half(rs, rc, 1'b0, MUL_OP_HI);
        drive_tree(rs, rc, 1'b0, MUL_OP_HI, 4'd3);
        tick();
        tree_valid = 1'b0;
        issue_fire = 1'b1;
        tick();
        issue_fire = 1'b0;
        check("t5_count_full", can_issue, 1'b0);
        rs = rnd64(); rc = rnd64(); exp_d[4] = ref_half(rs, rc, 1'b1, MUL_OP_LO);
        drive_tree(rs, rc, 1'b1, MUL_OP_LO, 4'd4);
        tick();
        tree_valid = 1'b0;
        tick(); tick(); tick();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t5_tag", out_tag, 4'(i));
            check("t5_data", out_data, exp_d[i]);
            tick();
        end
        out_ready = 1'b0;
        check("t5_drained", out_valid, 1'b0);
        check("t5_credit", can_issue, 1'b1);

        // Reset with two results buffered and two in the adder pipeline.
        send(rnd64(), rnd64(), 1'b0, MUL_OP_LO, 4'd8);
        send(rnd64(), rnd64(), 1'b0, MUL_OP_LO, 4'd9);
        tick(); tick(); tick();
        issue_fire = 1'b1;
        tick(); tick();
        issue_fire = 1'b0;
        drive_tree(rnd64(), rnd64(), 1'b1, MUL_OP_HI, 4'd10);
        tick();
        drive_tree(rnd64(), rnd64(), 1'b1, MUL_OP_HI, 4'd11);
        tick();
        tree_valid = 1'b0;
        check("t6_pre_valid", out_valid, 1'b1);
        resetn = 1'b0;
        #1;
        check("t6_async_valid", out_valid, 1'b0);
        check("t6_async_credit", can_issue, 1'b1);
        check("t6_async_data", out_data, 32'h0);
        tick();
        resetn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_no_stale", out_valid, 1'b0);
        end
        out_ready = 1'b0;

        // Random traffic against the arithmetic model and an in-order scoreboard.
        nop = '{v: 1'b0, s: '0, c: '0, cin: 1'b0, op: 1'b0, tag: '0};
        p0 = nop; p1 = nop;
        next_tag = '0;
        cnt_m = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            out_ready = (cyc >= 500) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            check("rnd_can_issue", can_issue, 1'(cnt_m < DEPTH));
            issue = (cyc < 500) && (cnt_m < DEPTH) && ($urandom_range(0, 3) != 0);
            fire  = out_valid && out_ready;
            if (fire) begin
                if (expq.size() == 0) begin
                    check("rnd_spurious", out_valid, 1'b0);
                end else begin
                    e = expq.pop_front();
                    check("rnd_tag", out_tag, e[35:32]);
                    check("rnd_data", out_data, e[31:0]);
                end
            end
            if (p1.v) drive_tree(p1.s, p1.c, p1.cin, p1.op, p1.tag);
            else tree_valid = 1'b0;
            p1 = p0;
            p0 = nop;
            if (issue) begin
                p0.v   = 1'b1;
                p0.s   = rnd64();
                p0.c   = rnd64();
                p0.cin = 1'($urandom_range(0, 1));
                p0.op  = 1'($urandom_range(0, 1));
                p0.tag = next_tag;
                expq.push_back({next_tag, ref_half(p0.s, p0.c, p0.cin, p0.op)});
                next_tag = next_tag + 4'd1;
            end
            cnt_m = cnt_m + (issue ? 1 : 0) - (fire ? 1 : 0);
            issue_fire = issue;
            tick();
        end
        issue_fire = 1'b0;
        tree_valid = 1'b0;
        check("rnd_drained", 64'(expq.size()), 64'd0);
        check("rnd_final_valid", out_valid, 1'b0);
        check("rnd_final_credit", can_issue, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
